// File: rtl/eros_obi_fwd_demux.sv
// Per-master 1-to-2 OBI forward demultiplexer: splits requests between the crossbar
// and the safe-CPU register port and returns responses in order.
module eros_obi_fwd_demux #(
  parameter int unsigned MaxTrans     = 4,
  parameter logic [31:0] RegStartAddr = 32'h0002_0000,
  parameter logic [31:0] RegEndAddr   = 32'h0002_1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m_req_i,
  output logic        m_gnt_o,
  input  logic [31:0] m_addr_i,
  input  logic        m_we_i,
  input  logic [3:0]  m_be_i,
  input  logic [31:0] m_wdata_i,
  output logic        m_rvalid_o,
  output logic [31:0] m_rdata_o,
  output logic        xbar_req_o,
  input  logic        xbar_gnt_i,
  output logic [31:0] xbar_addr_o,
  output logic        xbar_we_o,
  output logic [3:0]  xbar_be_o,
  output logic [31:0] xbar_wdata_o,
  input  logic        xbar_rvalid_i,
  input  logic [31:0] xbar_rdata_i,
  output logic        reg_req_o,
  input  logic        reg_gnt_i,
  output logic [31:0] reg_addr_o,
  output logic        reg_we_o,
  output logic [3:0]  reg_be_o,
  output logic [31:0] reg_wdata_o,
  input  logic        reg_rvalid_i,
  input  logic [31:0] reg_rdata_i,
  output logic        err_o
);

  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTrans);

  logic [CntW-1:0] cnt_q;
  logic            tgt_q;
  logic            sel;
  logic            busy;
  logic            stall;
  logic            gnt;
  logic            accept;
  logic            rvalid;
  logic            err;

  assign sel    = (m_addr_i >= RegStartAddr) && (m_addr_i < RegEndAddr);
  assign busy   = (cnt_q != '0);
  assign stall  = (cnt_q == MaxCnt) || (busy && (sel != tgt_q));
  assign gnt    = !stall && (sel ? reg_gnt_i : xbar_gnt_i);
  assign accept = m_req_i && gnt;
  assign rvalid = busy && (tgt_q ? reg_rvalid_i : xbar_rvalid_i);

  // Any response from the port we are not waiting on, or with nothing pending, is dropped.
  assign err = (xbar_rvalid_i && (!busy || tgt_q)) ||
               (reg_rvalid_i  && (!busy || !tgt_q));

  always_comb begin
    m_gnt_o      = 1'b0;
    xbar_req_o   = 1'b0;
    reg_req_o    = 1'b0;
    xbar_addr_o  = '0;
    xbar_we_o    = 1'b0;
    xbar_be_o    = '0;
    xbar_wdata_o = '0;
    reg_addr_o   = '0;
    reg_we_o     = 1'b0;
    reg_be_o     = '0;
    reg_wdata_o  = '0;
    m_rvalid_o   = 1'b0;
    m_rdata_o    = '0;
    err_o        = 1'b0;
    if (!rst_i) begin
      m_gnt_o      = gnt;
      xbar_req_o   = !stall && !sel && m_req_i;
      reg_req_o    = !stall && sel && m_req_i;
      xbar_addr_o  = m_addr_i;
      xbar_we_o    = m_we_i;
      xbar_be_o    = m_be_i;
      xbar_wdata_o = m_wdata_i;
      reg_addr_o   = m_addr_i;
      reg_we_o     = m_we_i;
      reg_be_o     = m_be_i;
      reg_wdata_o  = m_wdata_i;
      m_rvalid_o   = rvalid;
      m_rdata_o    = rvalid ? (tgt_q ? reg_rdata_i : xbar_rdata_i) : '0;
      err_o        = err;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tgt_q <= 1'b0;
    end else begin
      if (accept) begin
        tgt_q <= sel;
      end
      if (accept && !rvalid) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!accept && rvalid) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eros_obi_fwd_demux.sv
// Directed self-checking bench for eros_obi_fwd_demux: routing, stalls, in-order
// response return, error pulses and asynchronous reset.
module tb_eros_obi_fwd_demux;

  localparam logic [31:0] START = 32'h0002_0000;
  localparam logic [31:0] STOP  = 32'h0002_1000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m_req_i;
  logic        m_gnt_o;
  logic [31:0] m_addr_i;
  logic        m_we_i;
  logic [3:0]  m_be_i;
  logic [31:0] m_wdata_i;
  logic        m_rvalid_o;
  logic [31:0] m_rdata_o;
  logic        xbar_req_o;
  logic        xbar_gnt_i;
  logic [31:0] xbar_addr_o;
  logic        xbar_we_o;
  logic [3:0]  xbar_be_o;
  logic [31:0] xbar_wdata_o;
  logic        xbar_rvalid_i;
  logic [31:0] xbar_rdata_i;
  logic        reg_req_o;
  logic        reg_gnt_i;
  logic [31:0] reg_addr_o;
  logic        reg_we_o;
  logic [3:0]  reg_be_o;
  logic [31:0] reg_wdata_o;
  logic        reg_rvalid_i;
  logic [31:0] reg_rdata_i;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  eros_obi_fwd_demux #(
    .MaxTrans    (4),
    .RegStartAddr(START),
    .RegEndAddr  (STOP)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .m_req_i      (m_req_i),
    .m_gnt_o      (m_gnt_o),
    .m_addr_i     (m_addr_i),
    .m_we_i       (m_we_i),
    .m_be_i       (m_be_i),
    .m_wdata_i    (m_wdata_i),
    .m_rvalid_o   (m_rvalid_o),
    .m_rdata_o    (m_rdata_o),
    .xbar_req_o   (xbar_req_o),
    .xbar_gnt_i   (xbar_gnt_i),
    .xbar_addr_o  (xbar_addr_o),
    .xbar_we_o    (xbar_we_o),
    .xbar_be_o    (xbar_be_o),
    .xbar_wdata_o (xbar_wdata_o),
    .xbar_rvalid_i(xbar_rvalid_i),
    .xbar_rdata_i (xbar_rdata_i),
    .reg_req_o    (reg_req_o),
    .reg_gnt_i    (reg_gnt_i),
    .reg_addr_o   (reg_addr_o),
    .reg_we_o     (reg_we_o),
    .reg_be_o     (reg_be_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_rvalid_i (reg_rvalid_i),
    .reg_rdata_i  (reg_rdata_i),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it, where the next inputs are applied.
  task automatic applyStimulus();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_i = 1'b1; m_req_i = 1'b1; m_addr_i = 32'h0001_0000; m_we_i = 1'b0;
    m_be_i = 4'hF; m_wdata_i = 32'h1234_5678;
    xbar_gnt_i = 1'b1; reg_gnt_i = 1'b1;
    xbar_rvalid_i = 1'b0; xbar_rdata_i = 32'h0;
    reg_rvalid_i = 1'b0; reg_rdata_i = 32'h0;
    settle();
    checkOutput("rst_gnt", {31'd0, m_gnt_o}, 32'd0);
    checkOutput("rst_xreq", {31'd0, xbar_req_o}, 32'd0);
    checkOutput("rst_xaddr", xbar_addr_o, 32'd0);
    checkOutput("rst_cnt", 32'(dut.cnt_q), 32'd0);

    // Single port-0 read with a two-cycle response delay.
    applyStimulus();
    rst_i = 1'b0;
    settle();
    checkOutput("rd_xreq", {31'd0, xbar_req_o}, 32'd1);
    checkOutput("rd_rreq", {31'd0, reg_req_o}, 32'd0);
    checkOutput("rd_gnt", {31'd0, m_gnt_o}, 32'd1);
    checkOutput("rd_xaddr", xbar_addr_o, 32'h0001_0000);
    checkOutput("rd_raddr", reg_addr_o, 32'h0001_0000);
    applyStimulus();
    m_req_i = 1'b0;
    applyStimulus();
    xbar_rvalid_i = 1'b1; xbar_rdata_i = 32'hDEAD_BEEF;
    settle();
    checkOutput("rd_rvalid", {31'd0, m_rvalid_o}, 32'd1);
    checkOutput("rd_rdata", m_rdata_o, 32'hDEAD_BEEF);
    checkOutput("rd_err", {31'd0, err_o}, 32'd0);
    applyStimulus();
    xbar_rvalid_i = 1'b0;
    settle();
    checkOutput("rd_cnt0", 32'(dut.cnt_q), 32'd0);
    checkOutput("rd_rdata_idle", m_rdata_o, 32'd0);

    // Window boundaries: start and end-4 hit the register port, end goes to crossbar.
    m_req_i = 1'b1; m_we_i = 1'b1; m_addr_i = START;
    settle();
    checkOutput("wr_start_rreq", {31'd0, reg_req_o}, 32'd1);
    checkOutput("wr_start_xreq", {31'd0, xbar_req_o}, 32'd0);
    checkOutput("wr_start_gnt", {31'd0, m_gnt_o}, 32'd1);
    applyStimulus();
    m_addr_i = STOP - 32'd4;
    settle();
    checkOutput("wr_endm4_rreq", {31'd0, reg_req_o}, 32'd1);
    checkOutput("wr_endm4_gnt", {31'd0, m_gnt_o}, 32'd1);
    applyStimulus();
    m_addr_i = STOP;
    settle();
    checkOutput("wr_end_stall_gnt", {31'd0, m_gnt_o}, 32'd0);
    checkOutput("wr_end_stall_xreq", {31'd0, xbar_req_o}, 32'd0);
    checkOutput("wr_end_stall_rreq", {31'd0, reg_req_o}, 32'd0);
    checkOutput("wr_cnt2", 32'(dut.cnt_q), 32'd2);
    reg_rvalid_i = 1'b1; reg_rdata_i = 32'hA5A5_0001;
    settle();
    checkOutput("wr_resp1", {31'd0, m_rvalid_o}, 32'd1);
    checkOutput("wr_resp1_data", m_rdata_o, 32'hA5A5_0001);
    applyStimulus();
    settle();
    checkOutput("wr_resp2", {31'd0, m_rvalid_o}, 32'd1);
    checkOutput("wr_resp2_stall", {31'd0, m_gnt_o}, 32'd0);
    applyStimulus();
    reg_rvalid_i = 1'b0;
    settle();
    checkOutput("wr_end_xreq", {31'd0, xbar_req_o}, 32'd1);
    checkOutput("wr_end_gnt", {31'd0, m_gnt_o}, 32'd1);
    applyStimulus();
    m_req_i = 1'b0; xbar_rvalid_i = 1'b1; xbar_rdata_i = 32'h0;
    applyStimulus();
    xbar_rvalid_i = 1'b0;
    settle();
    checkOutput("wr_cnt0", 32'(dut.cnt_q), 32'd0);

    // Fill to MaxTrans, then one response frees a slot for the fifth request.
    m_req_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h0000_0100;
    repeat (4) applyStimulus();
    settle();
    checkOutput("full_cnt", 32'(dut.cnt_q), 32'd4);
    checkOutput("full_gnt", {31'd0, m_gnt_o}, 32'd0);
    checkOutput("full_xreq", {31'd0, xbar_req_o}, 32'd0);
    xbar_rvalid_i = 1'b1; xbar_rdata_i = 32'h0000_0011;
    settle();
    checkOutput("full_resp_stall", {31'd0, m_gnt_o}, 32'd0);
    checkOutput("full_resp_data", m_rdata_o, 32'h0000_0011);
    applyStimulus();
    xbar_rvalid_i = 1'b0;
    settle();
    checkOutput("full_cnt3", 32'(dut.cnt_q), 32'd3);
    checkOutput("full_fifth_gnt", {31'd0, m_gnt_o}, 32'd1);
    applyStimulus();
    m_req_i = 1'b0; xbar_rvalid_i = 1'b1;
    repeat (4) applyStimulus();
    xbar_rvalid_i = 1'b0;
    settle();
    checkOutput("full_drain", 32'(dut.cnt_q), 32'd0);

    // Target switch waits for the port-0 response, then proceeds with no bubble.
    m_req_i = 1'b1; m_addr_i = 32'h0000_0200;
    applyStimulus();
    m_addr_i = START;
    settle();
    checkOutput("sw_stall0", {31'd0, m_gnt_o}, 32'd0);
    applyStimulus();
    checkOutput("sw_stall1", {31'd0, reg_req_o}, 32'd0);
    xbar_rvalid_i = 1'b1; xbar_rdata_i = 32'h0000_0222;
    settle();
    checkOutput("sw_stall_resp", {31'd0, m_gnt_o}, 32'd0);
    applyStimulus();
    xbar_rvalid_i = 1'b0;
    settle();
    checkOutput("sw_rreq", {31'd0, reg_req_o}, 32'd1);
    checkOutput("sw_gnt", {31'd0, m_gnt_o}, 32'd1);
    applyStimulus();
    m_req_i = 1'b0;
    settle();
    checkOutput("sw_tgt", {31'd0, dut.tgt_q}, 32'd1);
    reg_rvalid_i = 1'b1;
    applyStimulus();
    reg_rvalid_i = 1'b0;

    // Response from the wrong port is dropped with an error pulse.
    m_req_i = 1'b1; m_addr_i = 32'h0000_0300;
    applyStimulus();
    m_req_i = 1'b0; reg_rvalid_i = 1'b1; reg_rdata_i = 32'hBAD0_BAD0;
    settle();
    checkOutput("wp_err", {31'd0, err_o}, 32'd1);
    checkOutput("wp_rvalid", {31'd0, m_rvalid_o}, 32'd0);
    checkOutput("wp_rdata", m_rdata_o, 32'd0);
    applyStimulus();
    reg_rvalid_i = 1'b0;
    settle();
    checkOutput("wp_err_clr", {31'd0, err_o}, 32'd0);
    checkOutput("wp_cnt", 32'(dut.cnt_q), 32'd1);
    xbar_rvalid_i = 1'b1;
    applyStimulus();
    xbar_rvalid_i = 1'b0;

    // Asynchronous reset with three outstanding, then a stray late response.
    m_req_i = 1'b1; m_addr_i = 32'h0000_0400;
    repeat (3) applyStimulus();
    settle();
    checkOutput("ar_cnt3", 32'(dut.cnt_q), 32'd3);
    #2;
    rst_i = 1'b1;
    settle();
    checkOutput("ar_cnt", 32'(dut.cnt_q), 32'd0);
    checkOutput("ar_gnt", {31'd0, m_gnt_o}, 32'd0);
    checkOutput("ar_xreq", {31'd0, xbar_req_o}, 32'd0);
    checkOutput("ar_waddr", xbar_addr_o, 32'd0);
    applyStimulus();
    rst_i = 1'b0; m_req_i = 1'b0; xbar_rvalid_i = 1'b1; xbar_rdata_i = 32'h0000_0444;
    settle();
    checkOutput("ar_stray_err", {31'd0, err_o}, 32'd1);
    checkOutput("ar_stray_rvalid", {31'd0, m_rvalid_o}, 32'd0);
    applyStimulus();
    xbar_rvalid_i = 1'b0;
    settle();
    checkOutput("ar_stray_cnt", 32'(dut.cnt_q), 32'd0);
    checkOutput("ar_err_clr", {31'd0, err_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
